// File: rtl/serial_rx.sv
// serial_rx: 8N1 UART receiver with two-flop input sync,
// mid-bit sampling, ready strobe and framing-error strobe.
module serial_rx #(
  parameter int CLKS_PER_BIT = 12
) (
  input  logic       clk12,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rbyte,
  output logic       rbyte_rdy,
  output logic       framing_err,
  output logic       busy
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_END = CW'(HALF - 1);
  localparam logic [CW-1:0] BIT_END = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t state, state_n;

  logic          rx_m, rx_s;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    shift, shift_n;
  logic [7:0]    rbyte_n;
  logic          rdy_n, ferr_n;

  // Sync flops idle high so reset never looks like a start bit.
  always_ff @(posedge clk12) begin
    if (reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk12) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      idx         <= '0;
      shift       <= '0;
      rbyte       <= '0;
      rbyte_rdy   <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      idx         <= idx_n;
      shift       <= shift_n;
      rbyte       <= rbyte_n;
      rbyte_rdy   <= rdy_n;
      framing_err <= ferr_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt + CW'(1);
    idx_n   = idx;
    shift_n = shift;
    rbyte_n = rbyte;
    rdy_n   = 1'b0;
    ferr_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (!rx_s) begin
          state_n = START;
          cnt_n   = '0;
        end
      end
      START: begin
        if (cnt == HALF_END) begin
          cnt_n = '0;
          if (rx_s) begin
            state_n = IDLE;
          end else begin
            state_n = DATA;
            idx_n   = '0;
          end
        end
      end
      DATA: begin
        if (cnt == BIT_END) begin
          cnt_n   = '0;
          shift_n = {rx_s, shift[7:1]};
          idx_n   = idx + 3'd1;
          if (idx == 3'd7) state_n = STOP;
        end
      end
      STOP: begin
        // Leave at mid-stop-bit so an abutting start bit is caught.
        if (cnt == BIT_END) begin
          cnt_n = '0;
          if (rx_s) begin
            rbyte_n = shift;
            rdy_n   = 1'b1;
            state_n = IDLE;
          end else begin
            ferr_n  = 1'b1;
            state_n = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        if (rx_s) begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  assign busy = (state != IDLE);

endmodule
